cv32e40p_alu3_tmr_ctrl: RTL and testbench

//  Sequencing and voting controller for the triplicated ALU (three cv32e40p_alu instances sharing operands).

---
 rtl/cv32e40p_alu3_tmr_ctrl_pkg.sv | 19 +
 rtl/cv32e40p_alu3_tmr_ctrl_vote.sv | 51 +++++
 rtl/cv32e40p_alu3_tmr_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_cv32e40p_alu3_tmr_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_alu3_tmr_ctrl_pkg.sv
// Shared types for the triplicated-ALU sequencing/voting controller.
// Voted word layout is {cmp, result}, so bit 32 is the comparison flag.
package cv32e40p_alu3_tmr_ctrl_pkg;

    localparam int TMR_WORD_W = 33;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RETRY,
        ST_OUT,
        ST_FATAL
    } tmr_state_e;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        popcount3 = 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

endpackage

// File: rtl/cv32e40p_alu3_tmr_ctrl_vote.sv
// Combinational 2-of-3 voter over 33-bit {cmp, result} words, restricted to the units in valid_i.
// faulty_o names the outvoted or missing unit; it is zero when the vote is clean or uncorrectable.
module cv32e40p_tmr_vote33
    import cv32e40p_alu3_tmr_ctrl_pkg::*;
(
    input  logic [TMR_WORD_W-1:0] word_1_i,
    input  logic [TMR_WORD_W-1:0] word_2_i,
    input  logic [TMR_WORD_W-1:0] word_3_i,
    input  logic [2:0]            valid_i,
    output logic [TMR_WORD_W-1:0] word_o,
    output logic                  m12_o,
    output logic                  m13_o,
    output logic                  m23_o,
    output logic [2:0]            faulty_o,
    output logic                  uncorr_o
);

    assign m12_o = (word_1_i == word_2_i);
    assign m13_o = (word_1_i == word_3_i);
    assign m23_o = (word_2_i == word_3_i);

    always_comb begin
        word_o   = (word_1_i & word_2_i) | (word_1_i & word_3_i) | (word_2_i & word_3_i);
        faulty_o = 3'b000;
        uncorr_o = 1'b0;
        case (valid_i)
            3'b111: begin
                if (m12_o && m13_o) begin
                    faulty_o = 3'b000;
                end else if (m12_o) begin
                    faulty_o = 3'b100;
                end else if (m13_o) begin
                    faulty_o = 3'b010;
                end else if (m23_o) begin
                    faulty_o = 3'b001;
                end else begin
                    uncorr_o = 1'b1;
                end
            end
            // With only two units present the absent one is the suspect.
            3'b011: begin word_o = word_1_i; faulty_o = 3'b100; uncorr_o = !m12_o; end
            3'b101: begin word_o = word_1_i; faulty_o = 3'b010; uncorr_o = !m13_o; end
            3'b110: begin word_o = word_2_i; faulty_o = 3'b001; uncorr_o = !m23_o; end
            default: uncorr_o = 1'b1;
        endcase
        if (uncorr_o) begin
            faulty_o = 3'b000;
        end
    end

endmodule

// File: rtl/cv32e40p_alu3_tmr_ctrl.sv
// Issues one op to three ALUs, votes {cmp,result}, masks one fault, retries, then latches fatal.
// Single-cycle op: accept cycle 0, capture cycle 1, out_valid_o cycle 2; OUT holds until out_ready_i.
module cv32e40p_alu3_tmr_ctrl
    import cv32e40p_alu3_tmr_ctrl_pkg::*;
#(
    parameter int SKEW_MAX  = 4,
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    output logic             alu_enable_o,
    output logic             alu_ex_ready_o,
    input  logic [31:0]      result_1_i,
    input  logic [31:0]      result_2_i,
    input  logic [31:0]      result_3_i,
    input  logic             cmp_1_i,
    input  logic             cmp_2_i,
    input  logic             cmp_3_i,
    input  logic             ready_1_i,
    input  logic             ready_2_i,
    input  logic             ready_3_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      result_o,
    output logic             comparison_result_o,
    output logic             corrected_o,
    output logic [2:0]       faulty_unit_o,
    output logic             fatal_o,
    output logic [CNT_W-1:0] err_count_o,
    input  logic             clr_err_i
);

    localparam int SK_W = $clog2(SKEW_MAX + 1);
    localparam int TM_W = $clog2(TIMEOUT);
    localparam int RT_W = $clog2(MAX_RETRY + 2);
    localparam logic [SK_W-1:0]  SKEW_LAST = SK_W'(SKEW_MAX - 1);
    localparam logic [TM_W-1:0]  TM_LAST   = TM_W'(TIMEOUT - 1);
    localparam logic [RT_W-1:0]  RT_LAST   = RT_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0] ERR_MAX   = '1;

    tmr_state_e       state_q, state_d;
    logic [TM_W-1:0]  timer_q, timer_d;
    logic [SK_W-1:0]  skew_q, skew_d;
    logic [RT_W-1:0]  retry_q, retry_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [31:0]      res_q, res_d;
    logic             cmp_q, cmp_d;
    logic             corr_q, corr_d;
    logic [2:0]       faulty_q, faulty_d;

    logic [2:0]            rdy;
    logic [1:0]            n_rdy;
    logic                  capture, clean, fail, err_inc;
    logic [TMR_WORD_W-1:0] vote_word;
    logic                  vote_m12, vote_m13, vote_m23, vote_uncorr;
    logic [2:0]            vote_faulty;

    assign rdy     = {ready_3_i, ready_2_i, ready_1_i};
    assign n_rdy   = popcount3(rdy);
    assign capture = (n_rdy == 2'd3) || ((n_rdy == 2'd2) && (skew_q == SKEW_LAST));
    assign clean   = (&rdy) && vote_m12 && vote_m13 && vote_m23;

    cv32e40p_tmr_vote33 u_vote (
        .word_1_i (TMR_WORD_W'({cmp_1_i, result_1_i})),
        .word_2_i (TMR_WORD_W'({cmp_2_i, result_2_i})),
        .word_3_i (TMR_WORD_W'({cmp_3_i, result_3_i})),
        .valid_i  (rdy),
        .word_o   (vote_word),
        .m12_o    (vote_m12),
        .m13_o    (vote_m13),
        .m23_o    (vote_m23),
        .faulty_o (vote_faulty),
        .uncorr_o (vote_uncorr)
    );

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        skew_d         = skew_q;
        retry_d        = retry_q;
        res_d          = res_q;
        cmp_d          = cmp_q;
        corr_d         = corr_q;
        faulty_d       = faulty_q;
        req_ready_o    = 1'b0;
        alu_enable_o   = 1'b0;
        alu_ex_ready_o = 1'b0;
        out_valid_o    = 1'b0;
        fatal_o        = 1'b0;
        err_inc        = 1'b0;
        fail           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = ST_EXEC;
                    retry_d = '0;
                    skew_d  = '0;
                    timer_d = '0;
                end
            end
            ST_EXEC: begin
                alu_enable_o = 1'b1;
                if (timer_q != TM_LAST) begin
                    timer_d = timer_q + TM_W'(1);
                end
                if (capture) begin
                    alu_ex_ready_o = 1'b1;
                    if (vote_uncorr) begin
                        fail = 1'b1;
                    end else begin
                        res_d    = vote_word[31:0];
                        cmp_d    = vote_word[32];
                        corr_d   = !clean;
                        faulty_d = vote_faulty;
                        err_inc  = !clean;
                        state_d  = ST_OUT;
                    end
                end else if (n_rdy == 2'd2) begin
                    skew_d = skew_q + SK_W'(1);
                end else if (timer_q == TM_LAST) begin
                    fail = 1'b1;
                end
                if (fail) begin
                    err_inc = 1'b1;
                    if (retry_q != RT_LAST) begin
                        retry_d = retry_q + RT_W'(1);
                        state_d = ST_RETRY;
                    end else begin
                        // Stale results from an earlier op must not show while fatal.
                        res_d    = '0;
                        cmp_d    = 1'b0;
                        corr_d   = 1'b0;
                        faulty_d = 3'b000;
                        state_d  = ST_FATAL;
                    end
                end
            end
            ST_RETRY: begin
                skew_d  = '0;
                timer_d = '0;
                state_d = ST_EXEC;
            end
            ST_OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FATAL: fatal_o = 1'b1;
            default:  state_d = ST_IDLE;
        endcase

        err_d = err_q;
        if (clr_err_i) begin
            err_d = '0;
        end else if (err_inc && (err_q != ERR_MAX)) begin
            err_d = err_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            skew_q   <= '0;
            retry_q  <= '0;
            err_q    <= '0;
            res_q    <= '0;
            cmp_q    <= 1'b0;
            corr_q   <= 1'b0;
            faulty_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            skew_q   <= skew_d;
            retry_q  <= retry_d;
            err_q    <= err_d;
            res_q    <= res_d;
            cmp_q    <= cmp_d;
            corr_q   <= corr_d;
            faulty_q <= faulty_d;
        end
    end

    assign result_o            = res_q;
    assign comparison_result_o = cmp_q;
    assign corrected_o         = corr_q;
    assign faulty_unit_o       = faulty_q;
    assign err_count_o         = err_q;

endmodule

// File: tb/tb_cv32e40p_alu3_tmr_ctrl.sv
// Bench for the TMR ALU controller: directed scenarios plus random ops checked against an
// attempt-level reference model (ready times and words per unit -> capture cycle and vote).
module tb_cv32e40p_alu3_tmr_ctrl;

    localparam int SKEW_MAX  = 4;
    localparam int TIMEOUT   = 64;
    localparam int MAX_RETRY = 2;
    localparam int CNT_W     = 4;
    localparam int ERR_MAX   = (1 << CNT_W) - 1;
    localparam int NEVER     = 1000;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid_i, req_ready_o, alu_enable_o, alu_ex_ready_o;
    logic [31:0]      result_1_i, result_2_i, result_3_i;
    logic             cmp_1_i, cmp_2_i, cmp_3_i;
    logic             ready_1_i, ready_2_i, ready_3_i;
    logic             out_valid_o, out_ready_i;
    logic [31:0]      result_o;
    logic             comparison_result_o, corrected_o, fatal_o, clr_err_i;
    logic [2:0]       faulty_unit_o;
    logic [CNT_W-1:0] err_count_o;

    always #5 clk = ~clk;

    cv32e40p_alu3_tmr_ctrl #(
        .SKEW_MAX(SKEW_MAX), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .alu_enable_o(alu_enable_o), .alu_ex_ready_o(alu_ex_ready_o),
        .result_1_i(result_1_i), .result_2_i(result_2_i), .result_3_i(result_3_i),
        .cmp_1_i(cmp_1_i), .cmp_2_i(cmp_2_i), .cmp_3_i(cmp_3_i),
        .ready_1_i(ready_1_i), .ready_2_i(ready_2_i), .ready_3_i(ready_3_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .comparison_result_o(comparison_result_o),
        .corrected_o(corrected_o), .faulty_unit_o(faulty_unit_o),
        .fatal_o(fatal_o), .err_count_o(err_count_o), .clr_err_i(clr_err_i)
    );

    int checks = 0;
    int errors = 0;
    int exp_err = 0;
    logic [32:0] aw [3][3];
    int          art [3][3];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [32:0] rnd33();
        logic [32:0] r;
        r[31:0] = $urandom;
        r[32]   = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic logic [32:0] nz33();
        logic [32:0] m;
        m = rnd33();
        if (m == '0) m = 33'd1;
        return m;
    endfunction

    task automatic drive_word(input int u, input logic [32:0] w, input logic r);
        case (u)
            0: begin result_1_i = w[31:0]; cmp_1_i = w[32]; ready_1_i = r; end
            1: begin result_2_i = w[31:0]; cmp_2_i = w[32]; ready_2_i = r; end
            default: begin result_3_i = w[31:0]; cmp_3_i = w[32]; ready_3_i = r; end
        endcase
    endtask

    task automatic drive_rand();
        for (int u = 0; u < 3; u++) drive_word(u, rnd33(), 1'($urandom_range(0, 1)));
    endtask

    task automatic set_att(input int a, input logic [32:0] w0, w1, w2, input int r0, r1, r2);
        aw[a][0] = w0; aw[a][1] = w1; aw[a][2] = w2;
        art[a][0] = r0; art[a][1] = r1; art[a][2] = r2;
    endtask

    // One attempt: which EXEC cycle ends it, whether it pulses ex_ready, and the vote outcome.
    task automatic model_att(input int a, output int len, output bit pulse, output bit ok,
                             output logic [2:0] fl, output logic [32:0] word);
        int mn, mx, t2, c, cnt;
        mn = art[a][0]; mx = art[a][0];
        for (int u = 1; u < 3; u++) begin
            if (art[a][u] < mn) mn = art[a][u];
            if (art[a][u] > mx) mx = art[a][u];
        end
        t2 = art[a][0] + art[a][1] + art[a][2] - mn - mx;
        ok = 1'b0; fl = 3'b000; word = '0; pulse = 1'b0;
        if (t2 > TIMEOUT) begin
            len = TIMEOUT;
        end else begin
            c = (mx < t2 + SKEW_MAX - 1) ? mx : t2 + SKEW_MAX - 1;
            len = c; pulse = 1'b1;
            for (int i = 0; i < 3; i++) begin
                cnt = 0;
                for (int j = 0; j < 3; j++)
                    if (art[a][i] <= c && art[a][j] <= c && aw[a][j] == aw[a][i]) cnt++;
                if (cnt >= 2) begin ok = 1'b1; word = aw[a][i]; end
            end
            if (ok)
                for (int u = 0; u < 3; u++) fl[u] = !(art[a][u] <= c && aw[a][u] == word);
        end
    endtask

    task automatic reset_check(input string p);
        chk({p, "_req_ready"}, req_ready_o, 1);
        chk({p, "_enable"}, alu_enable_o, 0);
        chk({p, "_ex_ready"}, alu_ex_ready_o, 0);
        chk({p, "_out_valid"}, out_valid_o, 0);
        chk({p, "_result"}, result_o, 0);
        chk({p, "_cmp"}, comparison_result_o, 0);
        chk({p, "_corrected"}, corrected_o, 0);
        chk({p, "_faulty"}, faulty_unit_o, 0);
        chk({p, "_fatal"}, fatal_o, 0);
        chk({p, "_err"}, err_count_o, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid_i = 1'b0; out_ready_i = 1'b0; clr_err_i = 1'b0;
        drive_rand();
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_err = 0;
        reset_check("reset");
    endtask

    task automatic run_op(input int hold, input bit clr_cap, input int rst_att, input int rst_cyc,
                          output bit fatal_seen);
        int len;
        bit pulse, ok, done;
        logic [2:0]  fl;
        logic [32:0] word;
        fatal_seen = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b1; out_ready_i = 1'b0; clr_err_i = 1'b0;
        drive_rand();
        #1;
        chk("idle_req_ready", req_ready_o, 1);
        chk("idle_ex_ready", alu_ex_ready_o, 0);
        chk("idle_enable", alu_enable_o, 0);
        done = 1'b0; ok = 1'b0; fl = 3'b000; word = '0;
        for (int a = 0; a <= MAX_RETRY && !done; a++) begin
            model_att(a, len, pulse, ok, fl, word);
            for (int k = 1; k <= len; k++) begin
                @(negedge clk);
                req_valid_i = 1'($urandom_range(0, 1));
                for (int u = 0; u < 3; u++) drive_word(u, aw[a][u], art[a][u] <= k);
                clr_err_i = clr_cap && a == 0 && k == len;
                #1;
                chk("exec_enable", alu_enable_o, 1);
                chk("exec_ex_ready", alu_ex_ready_o, (pulse && k == len) ? 1 : 0);
                chk("exec_out_valid", out_valid_o, 0);
                chk("exec_req_ready", req_ready_o, 0);
                if (a == rst_att && k == rst_cyc) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0; req_valid_i = 1'b0; clr_err_i = 1'b0;
                    #1;
                    exp_err = 0;
                    reset_check("abort");
                    return;
                end
            end
            if (clr_cap && a == 0) exp_err = 0;
            else if (!ok || fl != 3'b000) exp_err = (exp_err == ERR_MAX) ? ERR_MAX : exp_err + 1;
            if (ok) begin
                done = 1'b1;
            end else if (a < MAX_RETRY) begin
                @(negedge clk);
                clr_err_i = 1'b0; req_valid_i = 1'b0;
                drive_rand();
                #1;
                chk("retry_enable", alu_enable_o, 0);
                chk("retry_ex_ready", alu_ex_ready_o, 0);
                chk("retry_out_valid", out_valid_o, 0);
            end
        end
        if (ok) begin
            for (int h = 0; h <= hold; h++) begin
                @(negedge clk);
                clr_err_i = 1'b0; req_valid_i = 1'b0;
                out_ready_i = (h == hold);
                drive_rand();
                #1;
                chk("out_valid", out_valid_o, 1);
                chk("out_result", result_o, word[31:0]);
                chk("out_cmp", comparison_result_o, word[32]);
                chk("out_corrected", corrected_o, (fl != 3'b000) ? 1 : 0);
                chk("out_faulty", faulty_unit_o, fl);
                chk("out_req_ready", req_ready_o, 0);
                chk("out_ex_ready", alu_ex_ready_o, 0);
                chk("out_err", err_count_o, exp_err);
            end
        end else begin
            fatal_seen = 1'b1;
            for (int h = 0; h < 2; h++) begin
                @(negedge clk);
                clr_err_i = 1'b0; req_valid_i = 1'b1; out_ready_i = 1'b1;
                drive_rand();
                #1;
                chk("fatal_flag", fatal_o, 1);
                chk("fatal_req_ready", req_ready_o, 0);
                chk("fatal_enable", alu_enable_o, 0);
                chk("fatal_ex_ready", alu_ex_ready_o, 0);
                chk("fatal_out_valid", out_valid_o, 0);
                chk("fatal_result", result_o, 0);
                chk("fatal_corrected", corrected_o, 0);
                chk("fatal_faulty", faulty_unit_o, 0);
                chk("fatal_err", err_count_o, exp_err);
            end
        end
    endtask

    task automatic gen_att(input int a);
        logic [32:0] base, m1;
        int mode, sel, u;
        base = rnd33();
        for (int i = 0; i < 3; i++) begin aw[a][i] = base; art[a][i] = $urandom_range(1, 3); end
        mode = $urandom_range(0, 5);
        u = $urandom_range(0, 2);
        if (mode == 3) aw[a][u] = base ^ nz33();
        if (mode == 4) begin
            m1 = nz33();
            aw[a][1] = base ^ m1;
            aw[a][2] = base ^ m1 ^ nz33();
        end
        sel = $urandom_range(0, 19);
        if (sel == 0) for (int i = 0; i < 3; i++) art[a][i] = NEVER;
        else if (sel <= 3) art[a][u] = NEVER;
        else if (sel <= 6) art[a][u] = $urandom_range(4, 9);
        else if (sel == 7) begin art[a][u] = NEVER; art[a][(u + 1) % 3] = NEVER; end
    endtask

    initial begin
        bit fs;
        rst = 1'b1; req_valid_i = 1'b0; out_ready_i = 1'b0; clr_err_i = 1'b0;
        for (int u = 0; u < 3; u++) drive_word(u, '0, 1'b0);
        do_reset();

        set_att(0, 33'h0_0000_1234, 33'h0_0000_1234, 33'h0_0000_1234, 1, 1, 1);
        run_op(0, 1'b0, -1, -1, fs);
        chk("t1_err", err_count_o, 0);

        set_att(0, 33'h0_0000_00AA, 33'h0_FFFF_0000, 33'h0_0000_00AA, 1, 1, 1);
        run_op(1, 1'b0, -1, -1, fs);
        chk("t2_err", err_count_o, 1);

        set_att(0, 33'h0_0000_0055, 33'h0_0000_0055, 33'h1_0000_0055, 1, 1, NEVER);
        run_op(0, 1'b0, -1, -1, fs);
        chk("t4_err", err_count_o, 2);

        set_att(0, 33'h1_0000_0077, 33'h1_0000_0077, 33'h0_0000_0076, 1, 1, 1);
        run_op(10, 1'b1, -1, -1, fs);
        chk("t5_err_cleared", err_count_o, 0);

        set_att(0, 33'h0, 33'h0, 33'h0, NEVER, NEVER, NEVER);
        set_att(1, 33'h0, 33'h0, 33'h0, NEVER, NEVER, NEVER);
        run_op(0, 1'b0, 1, 3, fs);

        for (int n = 0; n < 150; n++) begin
            for (int a = 0; a < 3; a++) gen_att(a);
            run_op($urandom_range(0, 3), ($urandom_range(0, 9) == 0), -1, -1, fs);
            if (fs) do_reset();
        end

        do_reset();
        for (int a = 0; a < 3; a++)
            set_att(a, 33'h0_0000_0001, 33'h0_0000_0002, 33'h0_0000_0003, 1, 1, 1);
        run_op(0, 1'b0, -1, -1, fs);
        chk("t3_fatal", fatal_o, 1);
        chk("t3_req_ready", req_ready_o, 0);
        chk("t3_err", err_count_o, 3);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
